// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - branch resolution FSM driving an external registered comparator
module branch_resolver #(
  parameter int CNT_W = 16
) (
  input  logic             soc_clk,
  input  logic             reset,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [4:0]       br_op,
  input  logic [31:0]      br_pc,
  input  logic [31:0]      br_imm,
  input  logic [31:0]      br_rs1,
  input  logic [31:0]      br_rs2,
  output logic             cmp_dat_ready,
  output logic [31:0]      cmp_dat1,
  output logic [31:0]      cmp_dat2,
  output logic [4:0]       cmp_op,
  input  logic             cmp_con_met,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_next_pc,
  output logic             res_taken,
  output logic             res_illegal,
  output logic             res_misaligned,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESULT} state_t;

  state_t           state, state_n;
  logic [4:0]       op_q;
  logic [31:0]      pc_q, imm_q, rs1_q, rs2_q;
  logic [31:0]      next_pc_q;
  logic             taken_q, illegal_q, misaligned_q;
  logic [CNT_W-1:0] br_count_q, taken_count_q;
  logic             op_legal;
  logic [31:0]      target;

  assign op_legal = (br_op <= 5'd5);
  assign target   = pc_q + imm_q;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (br_valid) state_n = op_legal ? ISSUE : RESULT;
      ISSUE:   state_n = CAPTURE;
      CAPTURE: state_n = RESULT;
      RESULT:  if (res_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge soc_clk) begin
    if (!reset) begin
      state         <= IDLE;
      op_q          <= '0;
      pc_q          <= '0;
      imm_q         <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      next_pc_q     <= '0;
      taken_q       <= 1'b0;
      illegal_q     <= 1'b0;
      misaligned_q  <= 1'b0;
      br_count_q    <= '0;
      taken_count_q <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (br_valid) begin
          op_q         <= br_op;
          pc_q         <= br_pc;
          imm_q        <= br_imm;
          rs1_q        <= br_rs1;
          rs2_q        <= br_rs2;
          // Illegal ops skip the comparator, so their result is final at accept
          illegal_q    <= !op_legal;
          taken_q      <= 1'b0;
          misaligned_q <= 1'b0;
          next_pc_q    <= br_pc + 32'd4;
        end
        CAPTURE: begin
          taken_q      <= cmp_con_met;
          next_pc_q    <= cmp_con_met ? target : pc_q + 32'd4;
          misaligned_q <= cmp_con_met && (target[1:0] != 2'b00);
        end
        RESULT: if (res_ready && !illegal_q) begin
          if (br_count_q != '1) br_count_q <= br_count_q + 1'b1;
          if (taken_q && taken_count_q != '1) taken_count_q <= taken_count_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign br_ready       = (state == IDLE) && reset;
  assign cmp_dat_ready  = (state == ISSUE);
  assign cmp_dat1       = rs1_q;
  assign cmp_dat2       = rs2_q;
  assign cmp_op         = op_q;
  assign res_valid      = (state == RESULT);
  assign res_next_pc    = next_pc_q;
  assign res_taken      = taken_q;
  assign res_illegal    = illegal_q;
  assign res_misaligned = misaligned_q;
  assign br_count       = br_count_q;
  assign taken_count    = taken_count_q;

endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the statistics counters.
REQ-002 SHALL have port soc_clk, input, 1, the single clock; all logic updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-low reset, sampled on the rising edge of soc_clk.
REQ-004 SHALL have port br_valid, input, 1, a branch request is present.
REQ-005 SHALL have port br_ready, output, 1, the block can accept a request.
REQ-006 SHALL have port br_op, input, 5, ALU instruction code (0 BEQ, 1 BNE, 2 BLT, 3 BGE, 4 BLTU, 5 BGEU).
REQ-007 SHALL have ports br_pc, br_imm, br_rs1, br_rs2, input, 32 each: branch PC, sign-extended byte offset, and operands.
REQ-008 SHALL have port cmp_dat_ready, output, 1, drives the comparator dat_ready input.
REQ-009 SHALL have ports cmp_dat1, cmp_dat2, output, 32 each, and cmp_op, output, 5, driving the comparator operand and instruction inputs.
REQ-010 SHALL have port cmp_con_met, input, 1, the registered comparator condition result.
REQ-011 SHALL have port res_valid, output, 1, and res_ready, input, 1, the result handshake.
REQ-012 SHALL have ports res_next_pc, output, 32; res_taken, output, 1; res_illegal, output, 1; res_misaligned, output, 1.
REQ-013 SHALL have ports br_count and taken_count, output, CNT_W each: statistics counters.

Function
REQ-014 SHALL implement the FSM states IDLE, ISSUE, CAPTURE and RESULT.
REQ-015 SHALL assert br_ready only in IDLE; a request is accepted when br_valid and br_ready are both high on a rising edge.
REQ-016 On accept, SHALL latch br_op, br_pc, br_imm, br_rs1 and br_rs2, and drive cmp_dat1, cmp_dat2 and cmp_op from these latches until the block returns to IDLE.
REQ-017 On accept of a legal op (0-5), SHALL go to ISSUE; in ISSUE, cmp_dat_ready SHALL be 1 for exactly one cycle, with 0 in every other state.
REQ-018 SHALL go from ISSUE to CAPTURE; in CAPTURE, SHALL sample cmp_con_met and then go to RESULT.
REQ-019 SHALL set res_next_pc = pc + imm when taken, else pc + 4, both modulo 2^32 (silent wrap-around).
REQ-020 SHALL set res_misaligned = 1 only when taken and target[1:0] != 0; the target is still reported.
REQ-021 On accept of an illegal op (not 0-5), SHALL go directly to RESULT without pulsing cmp_dat_ready, with res_taken = 0, res_illegal = 1, and res_next_pc = pc + 4.
REQ-022 SHALL hold res_valid = 1 and all res_* outputs stable in RESULT until res_ready = 1, then go to IDLE on the next cycle.
REQ-023 Request accept into IDLE in the same cycle as the result handshake SHALL NOT occur; throughput is at most one branch per 4 cycles (legal) or 2 cycles (illegal).
REQ-024 Legal-op latency SHALL be: accept at edge T; cmp_dat_ready high in cycle T+1; cmp_con_met sampled at edge T+2; res_valid high from cycle T+3.
REQ-025 On each result handshake of a legal op, SHALL increment br_count, and SHALL also increment taken_count if res_taken = 1.
REQ-026 Both counters SHALL saturate at 2^CNT_W-1; illegal ops SHALL NOT count.
REQ-027 While not in RESULT, SHALL ignore res_ready and hold res_valid at 0.

Reset
REQ-028 When reset = 0 at a rising edge, SHALL enter IDLE regardless of state, discarding any in-flight branch.
REQ-029 Under reset, SHALL clear all outputs and latches to 0 (br_ready = 0 while reset is low, 1 in the first cycle after release), and clear both counters.
REQ-030 Reset asserted in CAPTURE or RESULT SHALL NOT produce a result handshake or a counter update.

Verification
REQ-031 BEQ with rs1 = rs2 = 0x5, pc = 0x100, imm = 0x20, res_ready = 1 -> cmp_dat_ready pulses in cycle T+1; res_valid in T+3 with next_pc = 0x120, taken = 1; br_count = 1, taken_count = 1.
REQ-032 BLT with rs1 = 0xFFFFFFFF, rs2 = 0x1 -> taken; BLTU with the same operands -> not taken, next_pc = pc + 4.
REQ-033 BNE taken with pc = 0xFFFFFFF0, imm = 0x20 -> next_pc = 0x00000010; with imm = 0x22 -> res_misaligned = 1.
REQ-034 op = 9 -> no cmp_dat_ready pulse; res_valid at T+1 with illegal = 1, next_pc = pc + 4; counters unchanged.
REQ-035 res_ready held 0 for 5 cycles -> res_* stable and br_ready = 0 throughout; completes one cycle after res_ready = 1.
REQ-036 Reset pulsed in CAPTURE -> no res_valid; after release, br_ready = 1 and counters = 0; preset br_count = 0xFFFF then one more branch -> stays 0xFFFF.
